// File: rtl/id_pkg.sv
// Shared decode definitions for the ID/EX stage: opcodes, ALU operand
// encodings and the 9-bit control bundle carried into EX.
package id_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_RTYPE = 2'b10,
        ALUOP_LOGIC = 2'b11
    } aluop_e;

    typedef enum logic [1:0] {
        SRCB_REG  = 2'b00,
        SRCB_SIMM = 2'b01,
        SRCB_ZIMM = 2'b10
    } srcb_e;

    // Field order matches the external ex_ctrl bit layout, MSB first.
    typedef struct packed {
        logic   reg_dst;
        aluop_e alu_op;
        srcb_e  alu_src_b;
        logic   mem_read;
        logic   mem_write;
        logic   reg_write;
        logic   mem_to_reg;
    } ctrl_t;

    localparam int unsigned CTRL_W = $bits(ctrl_t);
    localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/id_regfile.sv
// NREG x XLEN register file, two combinational reads, one synchronous write.
// Register 0 is hardwired to zero. Macro ID_WB_BYPASS_EN forwards the write port.
module id_regfile #(
    parameter  int unsigned XLEN = 32,
    parameter  int unsigned NREG = 32,
    localparam int unsigned RW   = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [RW-1:0]   raddr_a_i,
    input  logic [RW-1:0]   raddr_b_i,
    output logic [XLEN-1:0] rdata_a_o,
    output logic [XLEN-1:0] rdata_b_o,
    input  logic            we_i,
    input  logic [RW-1:0]   waddr_i,
    input  logic [XLEN-1:0] wdata_i
);

    logic [XLEN-1:0] regs_q [NREG];
    logic            wr_live;

    assign wr_live = we_i && (waddr_i != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_live) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    always_comb begin
        rdata_a_o = (raddr_a_i == '0) ? '0 : regs_q[raddr_a_i];
        rdata_b_o = (raddr_b_i == '0) ? '0 : regs_q[raddr_b_i];
`ifdef ID_WB_BYPASS_EN
        if (wr_live && (waddr_i == raddr_a_i)) rdata_a_o = wdata_i;
        if (wr_live && (waddr_i == raddr_b_i)) rdata_b_o = wdata_i;
`endif
    end

endmodule

// File: rtl/id_ex_stage.sv
// Decode stage with load-use hazard detection and the ID/EX pipeline register.
// Macro ID_WB_BYPASS_EN (in id_regfile) makes same-cycle writeback visible to decode.
module id_ex_stage
    import id_pkg::*;
#(
    parameter  int unsigned XLEN  = 32,
    parameter  int unsigned NREG  = 32,
    parameter  int unsigned IMM_W = 16,
    localparam int unsigned RW    = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_valid,
    input  logic [31:0]       if_instr,
    input  logic              flush,
    input  logic              wb_we,
    input  logic [RW-1:0]     wb_rd,
    input  logic [XLEN-1:0]   wb_data,
    output logic              stall_if,
    output logic              ex_valid,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic [XLEN-1:0]   ex_a,
    output logic [XLEN-1:0]   ex_b,
    output logic [XLEN-1:0]   ex_simm,
    output logic [XLEN-1:0]   ex_zimm,
    output logic [RW-1:0]     ex_rs,
    output logic [RW-1:0]     ex_rt,
    output logic [RW-1:0]     ex_rd,
    output logic [31:0]       ex_instr
);

    logic [5:0]       opcode;
    logic [RW-1:0]    rs_idx, rt_idx, rd_idx, dst_idx;
    logic [IMM_W-1:0] imm_field;
    logic [XLEN-1:0]  rdata_a, rdata_b, simm, zimm;
    ctrl_t            dec_ctrl;
    logic             uses_rt, load_use, accept;

    logic             ex_valid_d, ex_valid_q;
    ctrl_t            ex_ctrl_d, ex_ctrl_q;
    logic [XLEN-1:0]  ex_a_q, ex_b_q, ex_simm_q, ex_zimm_q;
    logic [RW-1:0]    ex_rs_q, ex_rt_q, ex_rd_q;
    logic [31:0]      ex_instr_q;

    assign opcode    = if_instr[31:26];
    assign rs_idx    = RW'(if_instr[25:21]);
    assign rt_idx    = RW'(if_instr[20:16]);
    assign rd_idx    = RW'(if_instr[15:11]);
    assign imm_field = if_instr[IMM_W-1:0];
    assign simm      = XLEN'($signed(imm_field));
    assign zimm      = XLEN'(imm_field);

    id_regfile #(
        .XLEN(XLEN),
        .NREG(NREG)
    ) u_regfile (
        .clk       (clk),
        .rst       (rst),
        .raddr_a_i (rs_idx),
        .raddr_b_i (rt_idx),
        .rdata_a_o (rdata_a),
        .rdata_b_o (rdata_b),
        .we_i      (wb_we),
        .waddr_i   (wb_rd),
        .wdata_i   (wb_data)
    );

    always_comb begin
        dec_ctrl = CTRL_NOP;
        case (opcode)
            OP_RTYPE: begin
                dec_ctrl.reg_dst   = 1'b1;
                dec_ctrl.alu_op    = ALUOP_RTYPE;
                dec_ctrl.alu_src_b = SRCB_REG;
                dec_ctrl.reg_write = 1'b1;
            end
            OP_LW: begin
                dec_ctrl.alu_op     = ALUOP_ADD;
                dec_ctrl.alu_src_b  = SRCB_SIMM;
                dec_ctrl.mem_read   = 1'b1;
                dec_ctrl.reg_write  = 1'b1;
                dec_ctrl.mem_to_reg = 1'b1;
            end
            OP_SW: begin
                dec_ctrl.alu_op    = ALUOP_ADD;
                dec_ctrl.alu_src_b = SRCB_SIMM;
                dec_ctrl.mem_write = 1'b1;
            end
            OP_ADDI: begin
                dec_ctrl.alu_op    = ALUOP_ADD;
                dec_ctrl.alu_src_b = SRCB_SIMM;
                dec_ctrl.reg_write = 1'b1;
            end
            OP_ANDI, OP_ORI: begin
                dec_ctrl.alu_op    = ALUOP_LOGIC;
                dec_ctrl.alu_src_b = SRCB_ZIMM;
                dec_ctrl.reg_write = 1'b1;
            end
            default: dec_ctrl = CTRL_NOP;
        endcase
    end

    assign dst_idx = dec_ctrl.reg_dst ? rd_idx : rt_idx;

    // rt is only a true source for R-type and sw; other I-types write it.
    assign uses_rt  = (opcode == OP_RTYPE) || (opcode == OP_SW);
    assign load_use = if_valid && ex_valid_q && ex_ctrl_q.mem_read && (ex_rd_q != '0) &&
                      ((ex_rd_q == rs_idx) || ((ex_rd_q == rt_idx) && uses_rt));
    assign stall_if = load_use && !flush && !rst;
    assign accept   = if_valid && !flush && !stall_if;

    always_comb begin
        ex_valid_d = accept;
        ex_ctrl_d  = accept ? dec_ctrl : CTRL_NOP;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid_q <= 1'b0;
            ex_ctrl_q  <= CTRL_NOP;
            ex_a_q     <= '0;
            ex_b_q     <= '0;
            ex_simm_q  <= '0;
            ex_zimm_q  <= '0;
            ex_rs_q    <= '0;
            ex_rt_q    <= '0;
            ex_rd_q    <= '0;
            ex_instr_q <= '0;
        end else begin
            ex_valid_q <= ex_valid_d;
            ex_ctrl_q  <= ex_ctrl_d;
            if (accept) begin
                ex_a_q     <= rdata_a;
                ex_b_q     <= rdata_b;
                ex_simm_q  <= simm;
                ex_zimm_q  <= zimm;
                ex_rs_q    <= rs_idx;
                ex_rt_q    <= rt_idx;
                ex_rd_q    <= dst_idx;
                ex_instr_q <= if_instr;
            end
        end
    end

    assign ex_valid = ex_valid_q;
    assign ex_ctrl  = ex_ctrl_q;
    assign ex_a     = ex_a_q;
    assign ex_b     = ex_b_q;
    assign ex_simm  = ex_simm_q;
    assign ex_zimm  = ex_zimm_q;
    assign ex_rs    = ex_rs_q;
    assign ex_rt    = ex_rt_q;
    assign ex_rd    = ex_rd_q;
    assign ex_instr = ex_instr_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: directed vectors push expectations,
// a negedge monitor pops and compares them by cycle number.
module tb_id_ex_stage;

    localparam logic [8:0] C_NOP  = 9'b0_00_00_0000;
    localparam logic [8:0] C_R    = 9'b1_10_00_0010;
    localparam logic [8:0] C_LW   = 9'b0_00_01_1011;
    localparam logic [8:0] C_SW   = 9'b0_00_01_0100;
    localparam logic [8:0] C_ADDI = 9'b0_00_01_0010;
    localparam logic [8:0] C_LOG  = 9'b0_11_10_0010;
`ifdef ID_WB_BYPASS_EN
    localparam logic [31:0] BYP_R9 = 32'h0000_1234;
`else
    localparam logic [31:0] BYP_R9 = 32'h0000_0000;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_valid = 1'b0;
    logic [31:0] if_instr = '0;
    logic        flush = 1'b0;
    logic        wb_we = 1'b0;
    logic [4:0]  wb_rd = '0;
    logic [31:0] wb_data = '0;
    logic        stall_if, ex_valid;
    logic [8:0]  ex_ctrl;
    logic [31:0] ex_a, ex_b, ex_simm, ex_zimm, ex_instr;
    logic [4:0]  ex_rs, ex_rt, ex_rd;

    id_ex_stage #(.XLEN(32), .NREG(32), .IMM_W(16)) dut (
        .clk(clk), .rst(rst), .if_valid(if_valid), .if_instr(if_instr),
        .flush(flush), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .stall_if(stall_if), .ex_valid(ex_valid), .ex_ctrl(ex_ctrl),
        .ex_a(ex_a), .ex_b(ex_b), .ex_simm(ex_simm), .ex_zimm(ex_zimm),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_instr(ex_instr)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        string       nm;
        bit          is_ex;
        bit          stall;
        bit          valid;
        bit          chk_data;
        logic [8:0]  ctrl;
        logic [31:0] a, b, simm, zimm, instr;
        logic [4:0]  rs, rt, rd;
    } exp_t;

    exp_t exq[$];
    exp_t e;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, req);
        end
    endtask

    always @(negedge clk) begin
        while (exq.size() > 0 && exq[0].cyc <= cyc) begin
            e = exq.pop_front();
            chk({e.nm, ".cycle"}, 32'(cyc), 32'(e.cyc));
            if (!e.is_ex) begin
                chk({e.nm, ".stall_if"}, {31'b0, stall_if}, {31'b0, e.stall});
            end else begin
                chk({e.nm, ".ex_valid"}, {31'b0, ex_valid}, {31'b0, e.valid});
                chk({e.nm, ".ex_ctrl"}, {23'b0, ex_ctrl}, {23'b0, e.ctrl});
                if (e.chk_data) begin
                    chk({e.nm, ".ex_a"}, ex_a, e.a);
                    chk({e.nm, ".ex_b"}, ex_b, e.b);
                    chk({e.nm, ".ex_simm"}, ex_simm, e.simm);
                    chk({e.nm, ".ex_zimm"}, ex_zimm, e.zimm);
                    chk({e.nm, ".ex_rs"}, {27'b0, ex_rs}, {27'b0, e.rs});
                    chk({e.nm, ".ex_rt"}, {27'b0, ex_rt}, {27'b0, e.rt});
                    chk({e.nm, ".ex_rd"}, {27'b0, ex_rd}, {27'b0, e.rd});
                    chk({e.nm, ".ex_instr"}, ex_instr, e.instr);
                end
            end
        end
    end

    function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
        return {6'b000000, rs, rt, rd, 5'd0, 6'h20};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    // Drives one decode cycle; expects stall_if now and the ID/EX contents after the edge.
    task automatic issue(input string nm, input bit r, input bit v, input logic [31:0] ins, input bit fl,
                         input bit we, input logic [4:0] wrd, input logic [31:0] wd,
                         input bit e_stall, input bit e_valid, input logic [8:0] e_ctrl,
                         input logic [31:0] e_a, input logic [31:0] e_b, input logic [4:0] e_rd);
        exp_t s, x;
        @(posedge clk);
        #1;
        rst = r; if_valid = v; if_instr = ins; flush = fl;
        wb_we = we; wb_rd = wrd; wb_data = wd;
        s = '{cyc: cyc, nm: nm, is_ex: 1'b0, stall: e_stall, valid: 1'b0, chk_data: 1'b0,
              ctrl: '0, a: '0, b: '0, simm: '0, zimm: '0, instr: '0, rs: '0, rt: '0, rd: '0};
        exq.push_back(s);
        x = s;
        x.cyc = cyc + 1;
        x.is_ex = 1'b1;
        if (r) begin
            x.chk_data = 1'b1;
        end else if (e_valid) begin
            x.valid = 1'b1;
            x.chk_data = 1'b1;
            x.ctrl = e_ctrl;
            x.a = e_a;
            x.b = e_b;
            x.simm = {{16{ins[15]}}, ins[15:0]};
            x.zimm = {16'h0000, ins[15:0]};
            x.instr = ins;
            x.rs = ins[25:21];
            x.rt = ins[20:16];
            x.rd = e_rd;
        end
        exq.push_back(x);
    endtask

    logic [31:0] LW2, ADD_USE;

    initial begin
        LW2     = enc_i(6'b100011, 5'd1, 5'd2, 16'h0000);
        ADD_USE = enc_r(5'd2, 5'd6, 5'd5);
        // reset held two edges with writeback and a load presented; both must be ignored
        issue("rst_a", 1, 1, LW2, 0, 1, 5'd5, 32'h55, 0, 0, C_NOP, 0, 0, 0);
        issue("rst_b", 1, 1, ADD_USE, 1, 1, 5'd5, 32'h55, 0, 0, C_NOP, 0, 0, 0);
        issue("rd_r5", 0, 1, enc_r(5'd5, 5'd0, 5'd8), 0, 0, 0, 0, 0, 1, C_R, 32'h0, 32'h0, 5'd8);
        issue("wb_r3", 0, 0, '0, 0, 1, 5'd3, 32'hA5, 0, 0, C_NOP, 0, 0, 0);
        issue("addi", 0, 1, enc_i(6'b001000, 5'd3, 5'd4, 16'hFFFE), 0, 0, 0, 0,
              0, 1, C_ADDI, 32'hA5, 32'h0, 5'd4);
        issue("wb_r6", 0, 0, '0, 0, 1, 5'd6, 32'h66, 0, 0, C_NOP, 0, 0, 0);
        // load-use on rs: one stall cycle, bubble, then the consumer enters
        issue("lw1", 0, 1, LW2, 0, 0, 0, 0, 0, 1, C_LW, 32'h0, 32'h0, 5'd2);
        issue("add_use", 0, 1, ADD_USE, 0, 0, 0, 0, 1, 0, C_NOP, 0, 0, 0);
        issue("add_retry", 0, 1, ADD_USE, 0, 0, 0, 0, 0, 1, C_R, 32'h0, 32'h66, 5'd5);
        issue("lw2", 0, 1, LW2, 0, 0, 0, 0, 0, 1, C_LW, 32'h0, 32'h0, 5'd2);
        issue("add_nouse", 0, 1, enc_r(5'd7, 5'd6, 5'd5), 0, 0, 0, 0, 0, 1, C_R, 32'h0, 32'h66, 5'd5);
        // rt hazard counts for sw but not for addi
        issue("lw3", 0, 1, LW2, 0, 0, 0, 0, 0, 1, C_LW, 32'h0, 32'h0, 5'd2);
        issue("sw_use", 0, 1, enc_i(6'b101011, 5'd1, 5'd2, 16'h0004), 0, 0, 0, 0, 1, 0, C_NOP, 0, 0, 0);
        issue("sw_retry", 0, 1, enc_i(6'b101011, 5'd1, 5'd2, 16'h0004), 0, 0, 0, 0,
              0, 1, C_SW, 32'h0, 32'h0, 5'd2);
        issue("lw4", 0, 1, LW2, 0, 0, 0, 0, 0, 1, C_LW, 32'h0, 32'h0, 5'd2);
        issue("addi_rt", 0, 1, enc_i(6'b001000, 5'd1, 5'd2, 16'h0001), 0, 0, 0, 0,
              0, 1, C_ADDI, 32'h0, 32'h0, 5'd2);
        // flush wins over a pending hazard
        issue("lw5", 0, 1, LW2, 0, 0, 0, 0, 0, 1, C_LW, 32'h0, 32'h0, 5'd2);
        issue("flush", 0, 1, ADD_USE, 1, 0, 0, 0, 0, 0, C_NOP, 0, 0, 0);
        issue("post_flush", 0, 1, ADD_USE, 0, 0, 0, 0, 0, 1, C_R, 32'h0, 32'h66, 5'd5);
        issue("lw_r0", 0, 1, enc_i(6'b100011, 5'd1, 5'd0, 16'h0000), 0, 0, 0, 0,
              0, 1, C_LW, 32'h0, 32'h0, 5'd0);
        issue("use_r0", 0, 1, enc_r(5'd0, 5'd6, 5'd5), 0, 0, 0, 0, 0, 1, C_R, 32'h0, 32'h66, 5'd5);
        // same-cycle writeback and read
        issue("wb_byp", 0, 1, enc_i(6'b001101, 5'd9, 5'd10, 16'h000F), 0, 1, 5'd9, 32'h1234,
              0, 1, C_LOG, BYP_R9, 32'h0, 5'd10);
        issue("rd_r9", 0, 1, enc_i(6'b001101, 5'd9, 5'd10, 16'h0000), 0, 0, 0, 0,
              0, 1, C_LOG, 32'h1234, 32'h0, 5'd10);
        issue("wb_r0", 0, 1, enc_r(5'd0, 5'd0, 5'd11), 0, 1, 5'd0, 32'hDEAD, 0, 1, C_R, 32'h0, 32'h0, 5'd11);
        issue("rd_r0", 0, 1, enc_r(5'd0, 5'd0, 5'd11), 0, 0, 0, 0, 0, 1, C_R, 32'h0, 32'h0, 5'd11);
        issue("ori_zimm", 0, 1, enc_i(6'b001101, 5'd0, 5'd1, 16'h8000), 0, 0, 0, 0,
              0, 1, C_LOG, 32'h0, 32'h0, 5'd1);
        issue("unknown", 0, 1, enc_i(6'b111111, 5'd9, 5'd3, 16'h1234), 0, 0, 0, 0,
              0, 1, C_NOP, 32'h1234, 32'hA5, 5'd3);
        issue("andi", 0, 1, enc_i(6'b001100, 5'd3, 5'd7, 16'h00F0), 0, 0, 0, 0,
              0, 1, C_LOG, 32'hA5, 32'h0, 5'd7);
        // reset overrides a pending hazard and clears the register file
        issue("lw6", 0, 1, LW2, 0, 0, 0, 0, 0, 1, C_LW, 32'h0, 32'h0, 5'd2);
        issue("rst_ovr", 1, 1, ADD_USE, 0, 1, 5'd3, 32'h77, 0, 0, C_NOP, 0, 0, 0);
        issue("after_rst", 0, 1, enc_r(5'd3, 5'd9, 5'd12), 0, 0, 0, 0, 0, 1, C_R, 32'h0, 32'h0, 5'd12);
        @(posedge clk);
        #1;
        if_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("queue_drained", 32'(exq.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 Parameters SHALL be: XLEN, default 32, datapath width; NREG, default 32, register count (power of 2, RW = log2 NREG); IMM_W, default 16, immediate field width.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 if_valid  in  1  if_instr holds a real instruction.
REQ-005 if_instr  in  32  instruction from IF/ID register.
REQ-006 flush  in  1  kill instruction currently in decode (branch redirect).
REQ-007 wb_we  in  1  writeback enable.
REQ-008 wb_rd  in  RW  writeback destination.
REQ-009 wb_data  in  XLEN  writeback value.
REQ-010 stall_if  out  1  hold PC and IF/ID this cycle (combinational).
REQ-011 ex_valid  out  1  ID/EX slot holds a live instruction.
REQ-012 ex_ctrl  out  9  {RegDst, ALUOp[1:0], ALUSrcB[1:0], MemRead, MemWrite, RegWrite, MemtoReg}.
REQ-013 ex_a, ex_b, ex_simm, ex_zimm  out  XLEN each  operand A, operand B, sign-extended imm, zero-extended imm.
REQ-014 ex_rs, ex_rt, ex_rd  out  RW each  source indices and resolved destination (rd if RegDst else rt).
REQ-015 ex_instr  out  32  instruction copy.

Function
REQ-016 Decode: opcode 000000 R-type (RegDst=1, ALUOp=10, ALUSrcB=00, RegWrite=1); 100011 lw (ALUOp=00, ALUSrcB=01, MemRead, RegWrite, MemtoReg); 101011 sw (ALUOp=00, ALUSrcB=01, MemWrite); 001000 addi (ALUOp=00, ALUSrcB=01, RegWrite); 001100/001101 andi/ori (ALUOp=11, ALUSrcB=10, RegWrite); any other opcode SHALL decode to all-zero control.
REQ-017 simm = IMM_W-bit field sign-extended to XLEN; zimm = zero-extended to XLEN.
REQ-018 Register file: NREG x XLEN, two combinational reads (rs=[25:21], rt=[20:16], truncated/extended to RW), one synchronous write when wb_we; register 0 SHALL read 0 and ignore writes.
REQ-019 Load-use hazard: stall_if=1 when if_valid & ex_valid & ex_ctrl.MemRead & ex_rd!=0 & (ex_rd==rs | (ex_rd==rt & decoded opcode is R-type or sw)).
REQ-020 Pipeline register: latency 1; on each edge, if flush or stall_if or !if_valid, ex_valid<=0 and ex_ctrl<=0 (bubble), other fields don't-care; else all ex_* load decoded values and ex_valid<=1.
REQ-021 flush SHALL take priority over hazard: stall_if forced 0 while flush=1.
REQ-022 A stall SHALL last exactly one cycle per load-use pair (bubble clears the MemRead match).
REQ-023 Simultaneous wb write and decode read of same register: behaviour per REQ-027.

Reset
REQ-024 While rst=1 at an edge: ex_valid=0, ex_ctrl=0, all ex_* data/index outputs 0, all registers 0.
REQ-025 rst SHALL override flush, stall and wb_we; stall_if SHALL be 0 in any cycle rst=1.
REQ-026 First edge after rst deasserts SHALL behave as normal operation.

Configuration
REQ-027 Macro ID_WB_BYPASS_EN: defined -> a read whose index equals wb_rd with wb_we=1 and wb_rd!=0 SHALL return wb_data same cycle; undefined -> read returns old contents, new value visible next cycle.

Structure
REQ-028 Package id_pkg SHALL hold opcode constants, ALUOp/ALUSrcB encodings, and the 9-bit control struct/width constant.
REQ-029 Register file SHALL be sub-module id_regfile (parameters XLEN, NREG); decode and hazard logic stay inline.

Verification
REQ-030 rst held 2 cycles, then released -> all ex_* 0, stall_if 0, reading r5 gives 0.
REQ-031 wb r3=0x0000_00A5, then addi r4,r3,-2 (imm 0xFFFE) -> ex_a=0xA5, ex_simm=0xFFFF_FFFE, ex_ctrl=0_00_01_0010, ex_rd=4.
REQ-032 lw r2,0(r1) then add r5,r2,r6 -> stall_if=1 one cycle, bubble (ex_valid=0), add enters next cycle; add r5,r7,r6 instead -> no stall.
REQ-033 flush=1 with lw-use hazard pending -> stall_if=0, next ex_valid=0.
REQ-034 wb_we=1 r9=0x1234 same cycle as or reading r9 -> ex_a=0x1234 with ID_WB_BYPASS_EN, old value without; write to r0 -> r0 still reads 0.
REQ-035 ori r1,r0,0x8000 -> ex_zimm=0x0000_8000, ALUSrcB=10; unknown opcode 111111 -> ex_ctrl=0, ex_valid=1.
